// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int baud_tick(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous show-ahead FIFO, head word visible on o_dout when not empty
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8O1 framing
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int             BAUD_TICK = baud_tick(CLK_FREQ, BAUD_RATE);
    localparam int             BCW       = $clog2(BAUD_TICK) + 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_TICK - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t      r_state, w_state_nxt;
    logic [BCW-1:0] r_baud_cnt, w_baud_nxt;
    logic [2:0]     r_bit_cnt, w_bit_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic           r_tx, w_tx_nxt;
    logic           w_baud_done;
    logic           w_pop;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic [7:0]     w_fifo_dout;

    assign o_ready     = ~w_full;
    assign w_push      = i_valid & o_ready;
    assign o_tx        = r_tx;
    assign o_busy      = (r_state != IDLE) | ~w_empty;
    assign w_baud_done = (r_baud_cnt == BAUD_LAST);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (i_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge i_clk) begin
        if (i_rst)      r_parity <= 1'b0;
        else if (w_pop) r_parity <= ~^w_fifo_dout;
    end
`endif

    // The line level is registered from the current state, so tx trails the state by one clock.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_nxt = r_parity;
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = STOP;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_nxt = '0;
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = w_fifo_dout;
                            w_state_nxt = START;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (BAUD_TICK = 10)
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int NBITS = 10 + NPAR;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data, data2;
    logic       valid, valid2;
    logic       ready, tx, busy;
    logic       ready2, tx2, busy2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4), .STOP_BITS(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready), .o_tx(tx), .o_busy(busy)
    );

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4), .STOP_BITS(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_data(data2), .i_valid(valid2),
        .o_ready(ready2), .o_tx(tx2), .o_busy(busy2)
    );

    // Receiver model: on a falling line, sample each bit at its middle clock.
    logic [11:0] q_frm [$];
    int          q_fall [$];
    int          mon_f;
    logic [11:0] mon_v;

    always begin
        @(negedge clk);
        if (rst === 1'b0 && tx === 1'b0) begin
            mon_f = cyc;
            mon_v = '0;
            for (int i = 0; i < NBITS; i++) begin
                while (cyc < mon_f + 10 * i + 5) @(negedge clk);
                mon_v[i] = tx;
            end
            q_frm.push_back(mon_v);
            q_fall.push_back(mon_f);
        end
    end

    function automatic logic [11:0] frame_of(input logic [7:0] b);
        logic [11:0] v;
        v      = '0;
        v[8:1] = b;
`ifdef UART_TX_PARITY_EN
        v[9]  = ~^b;
        v[10] = 1'b1;
`else
        v[9] = 1'b1;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Called at a negedge; returns the accepting edge number, again at a negedge.
    task automatic send(input logic [7:0] b, output int n);
        int t;
        t     = 0;
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", ready, 1);
        @(negedge clk);
        n     = cyc;
        valid = 1'b0;
    endtask

    task automatic wait_frames(input int cnt, input string tag);
        int t;
        t = 0;
        while (q_frm.size() < cnt && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, q_frm.size(), cnt);
    endtask

    logic [9:0]  a5_bits = 10'b1101001010;
    logic [7:0]  burst [5] = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
    logic [11:0] fr;
    logic        prev;
    int          n, n2, f, e1, edges, hi, t;

    initial begin
        rst = 1'b1; valid = 1'b0; data = '0; valid2 = 1'b0; data2 = '0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_tx2", tx2, 1);
        rst = 1'b0;

        edges = 0;
        prev  = tx;
        repeat (200) begin
            @(negedge clk);
            if (tx !== prev) edges++;
            prev = tx;
        end
        chk("idle_edges", edges, 0);
        chk("idle_frames", q_frm.size(), 0);

        // Single byte: latency, bit values, bit widths, busy release.
        send(8'hA5, n);
        goto(n + 1);
        chk("a5_pre_fall", tx, 1);
        goto(n + 2);
        chk("a5_fall", tx, 0);
        for (int i = 0; i < 9; i++) begin
            goto(n + 2 + 10 * i);
            chk($sformatf("a5_bit%0d_first", i), tx, a5_bits[i]);
            goto(n + 2 + 10 * i + 9);
            chk($sformatf("a5_bit%0d_last", i), tx, a5_bits[i]);
        end
        goto(n + 10 * NBITS);
        chk("a5_busy_hold", busy, 1);
        goto(n + 10 * NBITS + 1);
        chk("a5_busy_drop", busy, 0);
        chk("a5_nframes", q_frm.size(), 1);
        fr = q_frm[0];
        chk("a5_frame", fr[9:0], a5_bits);
        chk("a5_frame_full", fr, frame_of(8'hA5));
        q_frm.delete();
        q_fall.delete();

        // Burst with valid held: five accepts, then back-pressure.
        valid = 1'b1;
        e1    = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            data = burst[i];
            chk($sformatf("burst_ready%0d", i), ready, 1);
            @(negedge clk);
        end
        chk("burst_full", ready, 0);
        chk("burst_busy", busy, 1);
        valid = 1'b0;
        wait_frames(5, "burst_nframes");
        if (q_frm.size() == 5) begin
            chk("burst_first_fall", q_fall[0], e1 + 2);
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("burst_frame%0d", i), q_frm[i], frame_of(burst[i]));
                if (i > 0) chk($sformatf("burst_gap%0d", i), q_fall[i] - q_fall[i-1], 10 * NBITS);
            end
        end
        t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("burst_idle", busy, 0);
        q_frm.delete();
        q_fall.delete();

        // Reset mid-frame discards the frame and the queued byte.
        send(8'h0F, n);
        send(8'h77, n2);
        f = n + 2;
        goto(f + 36);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 1);
        rst = 1'b0;
        edges = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1) edges++;
        end
        chk("abort_quiet", edges, 0);
        q_frm.delete();
        q_fall.delete();
        send(8'hC3, n);
        wait_frames(1, "c3_nframes");
        if (q_frm.size() == 1) begin
            chk("c3_frame", q_frm[0], frame_of(8'hC3));
            chk("c3_fall", q_fall[0], n + 2);
        end
        q_frm.delete();
        q_fall.delete();

        // Parity bit position holds parity when enabled, else the stop bit.
        send(8'h07, n);
        send(8'h03, n);
        wait_frames(2, "par_nframes");
        if (q_frm.size() == 2) begin
            fr = q_frm[0];
`ifdef UART_TX_PARITY_EN
            chk("par_07", fr[9], 0);
            fr = q_frm[1];
            chk("par_03", fr[9], 1);
`else
            chk("par_07", fr[9], 1);
            fr = q_frm[1];
            chk("par_03", fr[9], 1);
`endif
            chk("par_07_frame", q_frm[0], frame_of(8'h07));
            chk("par_03_frame", q_frm[1], frame_of(8'h03));
        end

        // Two stop bits between back-to-back frames.
        data2  = 8'h01;
        valid2 = 1'b1;
        chk("s2_ready0", ready2, 1);
        @(negedge clk);
        e1 = cyc;
        chk("s2_ready1", ready2, 1);
        @(negedge clk);
        valid2 = 1'b0;
        f = e1 + 2;
        goto(f - 1);
        chk("s2_pre_fall", tx2, 1);
        goto(f);
        chk("s2_fall", tx2, 0);
        goto(f + 10 * (9 + NPAR) - 1);
        chk("s2_last_low", tx2, 0);
        hi = 0;
        @(negedge clk);
        while (tx2 === 1'b1 && hi < 60) begin
            hi++;
            @(negedge clk);
        end
        chk("s2_high_run", hi, 20);
        t = 0;
        while (busy2 !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("s2_idle", busy2, 0);
        chk("s2_tx_idle", tx2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
